// File: rtl/pim_unit_scheduler_pkg.sv
// pim_unit_scheduler_pkg: shared sizes and types for the pim_unit scheduler slice
// Matrix slices are flattened row-major, element i at bits [i*WIDTH +: WIDTH].
package pim_unit_scheduler_pkg;
    localparam int WIDTH             = 16;
    localparam int CHUNK_SIZE        = 2;
    localparam int PIM_UNIT_CAPACITY = 2;
    localparam int PIM_TIMEOUT       = 64;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
endpackage

// File: rtl/pim_unit_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after `last`
// The downward loop lets the nearest requester after `last` overwrite farther ones.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                grant = N'(1) << ((int'(last) + i) % N);
                idx   = IW'((int'(last) + i) % N);
            end
        end
    end
endmodule

// File: rtl/pim_unit_scheduler.sv
// pim_unit_scheduler: time-shares one pim_unit among NUM_REQ requesters
// Round-robin grant, operand latch, single-cycle issue, watchdog-bounded wait, zero-operand skip.
module pim_unit_scheduler
    import pim_unit_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = PIM_TIMEOUT
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [NUM_REQ-1:0]                                     req,
    input  logic [NUM_REQ*CHUNK_SIZE*PIM_UNIT_CAPACITY*WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*CHUNK_SIZE*PIM_UNIT_CAPACITY*WIDTH-1:0]  req_b,
    output logic [NUM_REQ-1:0]                                     gnt,
    output logic [NUM_REQ-1:0]                                     rsp_valid,
    output logic [CHUNK_SIZE*CHUNK_SIZE*WIDTH-1:0]                 rsp_result,
    output logic                                                   err_timeout,
    output logic                                                   pim_valid,
    output logic [CHUNK_SIZE*PIM_UNIT_CAPACITY*WIDTH-1:0]          pim_a,
    output logic [CHUNK_SIZE*PIM_UNIT_CAPACITY*WIDTH-1:0]          pim_b,
    input  logic [CHUNK_SIZE*CHUNK_SIZE*WIDTH-1:0]                 pim_result,
    input  logic                                                   pim_result_valid,
    output logic                                                   busy
);
    localparam int A_W = CHUNK_SIZE * PIM_UNIT_CAPACITY * WIDTH;
    localparam int R_W = CHUNK_SIZE * CHUNK_SIZE * WIDTH;
    localparam int IW  = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    sched_state_t     state_q, state_d;
    logic [IW-1:0]    last_q, last_d, w_q, w_d, arb_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d, err_q, err_d, pim_valid_q, pim_valid_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d, arb_grant, w_oh;
    logic [R_W-1:0]   rsp_result_q, rsp_result_d;
    logic [A_W-1:0]   pim_a_q, pim_a_d, pim_b_q, pim_b_d;
    logic             win_zero;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign win_zero = ~|req_a[arb_idx*A_W +: A_W] | ~|req_b[arb_idx*A_W +: A_W];
    assign w_oh     = NUM_REQ'(1) << w_q;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        w_d          = w_q;
        cnt_d        = cnt_q;
        zero_d       = zero_q;
        gnt_d        = '0;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        err_d        = 1'b0;
        pim_valid_d  = 1'b0;
        pim_a_d      = pim_a_q;
        pim_b_d      = pim_b_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d     = ISSUE;
                gnt_d       = arb_grant;
                last_d      = arb_idx;
                w_d         = arb_idx;
                zero_d      = win_zero;
                pim_valid_d = !win_zero;
                pim_a_d     = req_a[arb_idx*A_W +: A_W];
                pim_b_d     = req_b[arb_idx*A_W +: A_W];
            end
            // A zero-skip job passes through ISSUE silently so its response lands one cycle after gnt.
            ISSUE: begin
                cnt_d        = '0;
                state_d      = zero_q ? RESP : WAIT;
                rsp_valid_d  = zero_q ? w_oh : '0;
                rsp_result_d = zero_q ? '0 : rsp_result_q;
            end
            WAIT: if (pim_result_valid) begin
                state_d      = RESP;
                rsp_valid_d  = w_oh;
                rsp_result_d = pim_result;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d      = RESP;
                rsp_valid_d  = w_oh;
                rsp_result_d = '0;
                err_d        = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_q       <= IW'(NUM_REQ - 1);
            w_q          <= '0;
            cnt_q        <= '0;
            zero_q       <= 1'b0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            err_q        <= 1'b0;
            pim_valid_q  <= 1'b0;
            pim_a_q      <= '0;
            pim_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            w_q          <= w_d;
            cnt_q        <= cnt_d;
            zero_q       <= zero_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            err_q        <= err_d;
            pim_valid_q  <= pim_valid_d;
            pim_a_q      <= pim_a_d;
            pim_b_q      <= pim_b_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign err_timeout = err_q;
    assign pim_valid   = pim_valid_q;
    assign pim_a       = pim_a_q;
    assign pim_b       = pim_b_q;
    assign busy        = state_q != IDLE;
endmodule
